key_debouncer: RTL
==================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
- REQ-001: Parameter NUM_KEYS, default 3, is the number of independent push-button channels.
- REQ-002: Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), is the stable-sample count required to accept a level change; legal range is 1 to 2^CNT_W-1.
- REQ-003: Parameter CNT_W, default 20, is the width of each per-key debounce counter.
- REQ-004: Clk, input, 1, is the 50 MHz system clock; all state updates on its rising edge.
- REQ-005: Reset, input, 1, is a synchronous, active-high reset.
- REQ-006: Key_n, input, NUM_KEYS, carries raw active-low push-buttons; they are asynchronous and bouncing.
- REQ-007: SW, input, 16, carries raw asynchronous slider switches.
- REQ-008: SW_sync, output, 16, carries the switches after two-flop synchronization.
- REQ-009: Key_level_n, output, NUM_KEYS, carries debounced active-low button levels (0 = held), for direct use by downstream register-load logic.
- REQ-010: Key_press, output, NUM_KEYS, is a one-cycle pulse per key on each accepted press.
- REQ-011: Key_release, output, NUM_KEYS, is a one-cycle pulse per key on each accepted release.

Function
- REQ-012: Each Key_n bit and each SW bit shall pass through a two-flop synchronizer; SW_sync shall equal SW delayed by exactly 2 cycles.
- REQ-013: Each key shall have an independent 4-state FSM: UP, DOWN_PEND, DOWN, UP_PEND.
- REQ-014: In UP, a synchronized sample of 0 shall move the FSM to DOWN_PEND with counter = 0; otherwise the FSM shall stay in UP.
- REQ-015: In DOWN_PEND, a sample of 1 shall return the FSM to UP with counter = 0 and no pulse.
- REQ-016: In DOWN_PEND, a sample of 0 with counter < DEBOUNCE_CYCLES-1 shall increment the counter.
- REQ-017: In DOWN_PEND, a sample of 0 with counter == DEBOUNCE_CYCLES-1 shall move the FSM to DOWN.
- REQ-018: DOWN and UP_PEND shall mirror UP and DOWN_PEND with the sample polarity inverted; completing UP_PEND shall move the FSM to UP.
- REQ-019: Key_level_n shall be registered: 0 exactly while the FSM is in DOWN or UP_PEND, 1 otherwise.
- REQ-020: Key_press shall be 1 for exactly the one cycle following the edge of the DOWN_PEND->DOWN transition, coincident with the fall of Key_level_n.
- REQ-021: Key_release shall be 1 for exactly the one cycle following the edge of the UP_PEND->UP transition, coincident with the rise of Key_level_n.
- REQ-022: Latency: if the first synchronized 0 is sampled at edge k and the sample stays 0, Key_level_n shall fall at edge k+DEBOUNCE_CYCLES; the raw-to-output latency is DEBOUNCE_CYCLES+2 cycles.
- REQ-023: Any sample glitch during a PEND state shall abort the change; Key_level_n shall never toggle for a pulse shorter than DEBOUNCE_CYCLES+1 samples.
- REQ-024: Keys shall be fully independent; simultaneous presses on several keys shall produce simultaneous pulses with no interaction.
- REQ-025: The counter shall never wrap; it shall only be cleared or incremented per REQ-014 to REQ-018.

Reset
- REQ-026: While Reset = 1 at a clock edge, the block shall set every FSM to UP, every counter to 0, Key_level_n to all 1s, Key_press and Key_release to 0, the key synchronizer flops to 1 and the SW synchronizer flops and SW_sync to 0.
- REQ-027: A Reset during a PEND or DOWN state shall abort that state and generate no Key_release pulse.
- REQ-028: A key held through reset deassertion shall go through the full press debounce from UP.

Verification (DEBOUNCE_CYCLES = 4)
- REQ-029: Reset = 1 for 2 cycles with Key_n = 3'b000 -> Key_level_n = 3'b111 and no pulses; after Reset = 0, Key_level_n = 3'b000 after exactly 6 cycles, with a Key_press pulse of 3'b111 for 1 cycle.
- REQ-030: Key_n[1] low for 3 cycles, high for 1 cycle, low for 3 cycles -> Key_level_n[1] stays 1 and Key_press[1] stays 0 throughout.
- REQ-031: Key_n[0] held low for 20 cycles and then released -> Key_level_n[0] low from cycle 6 to cycle 26, with one Key_press[0] pulse and one Key_release[0] pulse.
- REQ-032: SW changes from 16'h0000 to 16'hA5C3 -> SW_sync = 16'hA5C3 exactly 2 cycles later.
- REQ-033: Key_n[2] pressed and accepted, then Reset = 1 for 1 cycle while the key is still held -> Key_level_n[2] = 1 the next cycle with no Key_release[2] pulse, then a re-press is accepted 6 cycles after Reset returns to 0.
- REQ-034: Key_n[0] and Key_n[2] fall on the same cycle -> Key_press = 3'b101 on a single cycle and Key_press[1] = 0.

Source files
------------

// File: rtl/key_debouncer.sv
// key_debouncer: two-flop synchronizers for push-buttons and slider switches,
// plus an independent four-state debounce FSM per push-button that produces a
// registered debounced level and one-cycle press/release pulses.
module key_debouncer #(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] Key_n,
    input  logic [15:0]         SW,
    output logic [15:0]         SW_sync,
    output logic [NUM_KEYS-1:0] Key_level_n,
    output logic [NUM_KEYS-1:0] Key_press,
    output logic [NUM_KEYS-1:0] Key_release
);

    typedef enum logic [1:0] {
        UP        = 2'd0,
        DOWN_PEND = 2'd1,
        DOWN      = 2'd2,
        UP_PEND   = 2'd3
    } state_t;

    // Last count value of a pending window; reaching it with a stable sample commits the change.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] key_sync_p0;
    logic [NUM_KEYS-1:0] key_sync_p1;
    logic [15:0]         sw_sync_p0;

    state_t              state     [NUM_KEYS];
    state_t              state_nxt [NUM_KEYS];
    logic [CNT_W-1:0]    cnt       [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_nxt   [NUM_KEYS];

    logic [NUM_KEYS-1:0] level_nxt;
    logic [NUM_KEYS-1:0] press_nxt;
    logic [NUM_KEYS-1:0] release_nxt;

    // Two-flop synchronizers; keys idle high (released), switches idle low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_sync_p0 <= '1;
            key_sync_p1 <= '1;
            sw_sync_p0  <= '0;
            SW_sync     <= '0;
        end else begin
            key_sync_p0 <= Key_n;
            key_sync_p1 <= key_sync_p0;
            sw_sync_p0  <= SW;
            SW_sync     <= sw_sync_p0;
        end
    end

    // State register: per-key FSM state and counter, plus the registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i] <= UP;
                cnt[i]   <= '0;
            end
            Key_level_n <= '1;
            Key_press   <= '0;
            Key_release <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            Key_level_n <= level_nxt;
            Key_press   <= press_nxt;
            Key_release <= release_nxt;
        end
    end

    // Next-state logic: any sample disagreeing with a pending change aborts it.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                UP: begin
                    if (!key_sync_p1[i]) begin
                        state_nxt[i] = DOWN_PEND;
                        cnt_nxt[i]   = '0;
                    end
                end
                DOWN_PEND: begin
                    if (key_sync_p1[i]) begin
                        state_nxt[i] = UP;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = DOWN;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i]   = cnt[i] + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_sync_p1[i]) begin
                        state_nxt[i] = UP_PEND;
                        cnt_nxt[i]   = '0;
                    end
                end
                UP_PEND: begin
                    if (!key_sync_p1[i]) begin
                        state_nxt[i] = DOWN;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = UP;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i]   = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = UP;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Output logic: level follows the committed state, pulses mark the committing transitions.
    always_comb begin
        level_nxt   = '1;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            level_nxt[i]   = !((state_nxt[i] == DOWN) || (state_nxt[i] == UP_PEND));
            press_nxt[i]   = (state[i] == DOWN_PEND) && (state_nxt[i] == DOWN);
            release_nxt[i] = (state[i] == UP_PEND) && (state_nxt[i] == UP);
        end
    end

endmodule
